// File: rtl/uvma_rvfi_pkg.sv
// Shared RVFI agent types: CSR serializer state, address width and beat payload.
package uvma_rvfi_pkg;

  localparam int unsigned CSR_ADDR_W   = 12;
  localparam int unsigned BEAT_XLEN    = 32;
  localparam int unsigned BEAT_ORDER_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } uvma_rvfi_csr_ser_state_t;

  typedef struct packed {
    logic [BEAT_ORDER_W-1:0] order;
    logic [BEAT_XLEN-1:0]    addr;
    logic [BEAT_XLEN-1:0]    rmask;
    logic [BEAT_XLEN-1:0]    wmask;
    logic [BEAT_XLEN-1:0]    rdata;
    logic [BEAT_XLEN-1:0]    wdata;
    logic                    last;
  } uvma_rvfi_csr_beat_t;

endpackage

// File: rtl/uvma_rvfi_csr_ser_prio_enc.sv
// Lowest-set-bit priority encoder: index, one-hot and any-set flag.
module uvma_rvfi_csr_ser_prio_enc #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic             any
);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign onehot = vec & (~vec + N'(1));
  assign any    = |vec;

endmodule

// File: rtl/uvma_rvfi_csr_serializer.sv
// Serializes one retirement's named-CSR snapshot into one beat per active slot.
// Optional sticky order check enabled by UVMA_RVFI_CSR_SER_ORDER_CHK_EN.
module uvma_rvfi_csr_serializer
  import uvma_rvfi_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned ORDER_W   = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ORDER_W-1:0]              in_order,
  input  logic [NUM_SLOTS*CSR_ADDR_W-1:0] in_addr,
  input  logic [NUM_SLOTS*XLEN-1:0]       in_rmask,
  input  logic [NUM_SLOTS*XLEN-1:0]       in_wmask,
  input  logic [NUM_SLOTS*XLEN-1:0]       in_rdata,
  input  logic [NUM_SLOTS*XLEN-1:0]       in_wdata,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ORDER_W-1:0]              out_order,
  output logic [XLEN-1:0]                 out_addr,
  output logic [XLEN-1:0]                 out_rmask,
  output logic [XLEN-1:0]                 out_wmask,
  output logic [XLEN-1:0]                 out_rdata,
  output logic [XLEN-1:0]                 out_wdata,
  output logic                            out_last,
  output logic                            drop_pulse
`ifdef UVMA_RVFI_CSR_SER_ORDER_CHK_EN
  ,
  output logic                            err_order
`endif
);

  localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  uvma_rvfi_csr_ser_state_t state_q, state_d;
  logic [NUM_SLOTS-1:0]  rem_q, rem_d, active_c, cur_onehot;
  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_any, last_c, emit_c, accept_c, capture_c;
  logic                  drop_q, drop_d;

  logic [ORDER_W-1:0]    order_q;
  logic [CSR_ADDR_W-1:0] addr_q  [NUM_SLOTS];
  logic [XLEN-1:0]       rmask_q [NUM_SLOTS];
  logic [XLEN-1:0]       wmask_q [NUM_SLOTS];
  logic [XLEN-1:0]       rdata_q [NUM_SLOTS];
  logic [XLEN-1:0]       wdata_q [NUM_SLOTS];

  uvma_rvfi_csr_ser_prio_enc #(.N(NUM_SLOTS), .IDX_W(IDX_W)) u_prio_enc (
    .vec    (rem_q),
    .idx    (cur_idx),
    .onehot (cur_onehot),
    .any    (cur_any)
  );

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      active_c[i] = |(in_rmask[i*XLEN +: XLEN] | in_wmask[i*XLEN +: XLEN]);
    end
  end

  assign last_c   = cur_any && ((rem_q & ~cur_onehot) == '0);
  assign emit_c   = reset_n && (state_q == EMIT);
  assign in_ready = reset_n && ((state_q == IDLE) || (out_ready && last_c));
  assign accept_c = in_valid && in_ready;

  // Advance on a beat handshake; a capture (idle or on the last handshake) overrides.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    capture_c = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      EMIT: begin
        if (out_ready) begin
          rem_d = rem_q & ~cur_onehot;
          if (last_c) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept_c) begin
      capture_c = 1'b1;
      if (|active_c) begin
        state_d = EMIT;
        rem_d   = active_c;
      end else begin
        state_d = IDLE;
        drop_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      order_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        addr_q[i]  <= '0;
        rmask_q[i] <= '0;
        wmask_q[i] <= '0;
        rdata_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else if (capture_c) begin
      order_q <= in_order;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        addr_q[i]  <= in_addr[i*CSR_ADDR_W +: CSR_ADDR_W];
        rmask_q[i] <= in_rmask[i*XLEN +: XLEN];
        wmask_q[i] <= in_wmask[i*XLEN +: XLEN];
        rdata_q[i] <= in_rdata[i*XLEN +: XLEN];
        wdata_q[i] <= in_wdata[i*XLEN +: XLEN];
      end
    end
  end

  assign out_valid  = emit_c;
  assign out_last   = emit_c && last_c;
  assign out_order  = emit_c ? order_q : '0;
  assign out_addr   = emit_c ? XLEN'(addr_q[cur_idx]) : '0;
  assign out_rmask  = emit_c ? rmask_q[cur_idx] : '0;
  assign out_wmask  = emit_c ? wmask_q[cur_idx] : '0;
  assign out_rdata  = emit_c ? rdata_q[cur_idx] : '0;
  assign out_wdata  = emit_c ? wdata_q[cur_idx] : '0;
  assign drop_pulse = drop_q;

`ifdef UVMA_RVFI_CSR_SER_ORDER_CHK_EN
  logic               seen_q;
  logic [ORDER_W-1:0] prev_order_q;

  // Sticky flag for a non-increasing order; first accept after reset has no reference.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_order    <= 1'b0;
      seen_q       <= 1'b0;
      prev_order_q <= '0;
    end else if (accept_c) begin
      seen_q       <= 1'b1;
      prev_order_q <= in_order;
      if (seen_q && (in_order <= prev_order_q)) err_order <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uvma_rvfi_csr_serializer.sv
// Self-checking bench for uvma_rvfi_csr_serializer: directed sequences, a vector table
// and a randomized run against a queue-based beat model.
module tb_uvma_rvfi_csr_serializer;

  localparam int NS = 8;
  localparam int XW = 32;
  localparam int OW = 64;

  logic            clk;
  logic            reset_n;
  logic            in_valid, in_ready;
  logic [OW-1:0]   in_order;
  logic [NS*12-1:0] in_addr;
  logic [NS*XW-1:0] in_rmask, in_wmask, in_rdata, in_wdata;
  logic            out_valid, out_ready, out_last, drop_pulse;
  logic [OW-1:0]   out_order;
  logic [XW-1:0]   out_addr, out_rmask, out_wmask, out_rdata, out_wdata;
`ifdef UVMA_RVFI_CSR_SER_ORDER_CHK_EN
  logic            err_order;
`endif

  uvma_rvfi_csr_serializer #(.XLEN(XW), .NUM_SLOTS(NS), .ORDER_W(OW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_order   (in_order),
    .in_addr    (in_addr),
    .in_rmask   (in_rmask),
    .in_wmask   (in_wmask),
    .in_rdata   (in_rdata),
    .in_wdata   (in_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_order  (out_order),
    .out_addr   (out_addr),
    .out_rmask  (out_rmask),
    .out_wmask  (out_wmask),
    .out_rdata  (out_rdata),
    .out_wdata  (out_wdata),
    .out_last   (out_last),
    .drop_pulse (drop_pulse)
`ifdef UVMA_RVFI_CSR_SER_ORDER_CHK_EN
    ,
    .err_order  (err_order)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] order;
    logic [XW-1:0] addr, rmask, wmask, rdata, wdata;
    logic          last;
  } beat_t;

  typedef struct {
    logic [7:0]  rsel;
    logic [7:0]  wsel;
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic        exp_drop;
  } vec_t;

  int      errors = 0;
  int      checks = 0;
  beat_t   q[$];
  logic    exp_drop = 1'b0;
  logic [OW-1:0] next_order = 64'd1000;
  vec_t    tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_snap();
    in_addr = '0; in_rmask = '0; in_wmask = '0; in_rdata = '0; in_wdata = '0;
  endtask

  task automatic set_slot(input int s, input logic [11:0] a, input logic [31:0] rm,
                          input logic [31:0] wm, input logic [31:0] rd, input logic [31:0] wd);
    in_addr[s*12 +: 12]  = a;
    in_rmask[s*XW +: XW] = rm;
    in_wmask[s*XW +: XW] = wm;
    in_rdata[s*XW +: XW] = rd;
    in_wdata[s*XW +: XW] = wd;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Reference: one beat per slot with a non-zero mask, ascending, last on the final one.
  task automatic push_beats(output int n);
    int idx[$];
    for (int s = 0; s < NS; s++)
      if ((in_rmask[s*XW +: XW] | in_wmask[s*XW +: XW]) != '0) idx.push_back(s);
    n = idx.size();
    foreach (idx[k]) begin
      beat_t b;
      b.order = in_order;
      b.addr  = {20'h0, in_addr[idx[k]*12 +: 12]};
      b.rmask = in_rmask[idx[k]*XW +: XW];
      b.wmask = in_wmask[idx[k]*XW +: XW];
      b.rdata = in_rdata[idx[k]*XW +: XW];
      b.wdata = in_wdata[idx[k]*XW +: XW];
      b.last  = (k == n - 1);
      q.push_back(b);
    end
  endtask

  task automatic gen_snap();
    int mode;
    mode = $urandom_range(0, 4);
    clr_snap();
    in_order = next_order;
    next_order = next_order + 64'd1;
    for (int s = 0; s < NS; s++) begin
      logic [31:0] rm, wm;
      rm = 32'h0; wm = 32'h0;
      if (mode != 0 && $urandom_range(0, 2) == 0) begin
        rm = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'h0;
        wm = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'h0;
        if (rm == 32'h0 && wm == 32'h0) rm = 32'h1;
      end
      set_slot(s, 12'($urandom), rm, wm, 32'($urandom), 32'($urandom));
    end
  endtask

  task automatic rand_cycle(input bit gen);
    logic exp_rdy;
    bit   hs, acc;
    int   n;
    out_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (gen && !in_valid && $urandom_range(0, 2) == 0) begin
      gen_snap();
      in_valid = 1'b1;
    end
    #1;
    exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
    chk("rnd_out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("rnd_order", out_order, q[0].order);
      chk("rnd_addr",  64'(out_addr),  64'(q[0].addr));
      chk("rnd_rmask", 64'(out_rmask), 64'(q[0].rmask));
      chk("rnd_wmask", 64'(out_wmask), 64'(q[0].wmask));
      chk("rnd_rdata", 64'(out_rdata), 64'(q[0].rdata));
      chk("rnd_wdata", 64'(out_wdata), 64'(q[0].wdata));
      chk("rnd_last",  64'(out_last),  64'(q[0].last));
    end
    chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("rnd_drop", 64'(drop_pulse), 64'(exp_drop));
`ifdef UVMA_RVFI_CSR_SER_ORDER_CHK_EN
    chk("rnd_err_order", 64'(err_order), 64'h0);
`endif
    hs  = (q.size() != 0) && out_ready;
    acc = in_valid && exp_rdy;
    exp_drop = 1'b0;
    if (hs) void'(q.pop_front());
    if (acc) begin
      push_beats(n);
      exp_drop = (n == 0);
    end
    @(posedge clk);
    #1;
    if (acc) in_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h20, 8'h02, 2, 32'h301, 32'h305, 1'b0};
    tbl[1] = '{8'h00, 8'h00, 0, 32'h0,   32'h0,   1'b1};
    tbl[2] = '{8'h80, 8'h00, 1, 32'h307, 32'h307, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 8, 32'h300, 32'h307, 1'b0};
    tbl[4] = '{8'h01, 8'h80, 2, 32'h300, 32'h307, 1'b0};
    tbl[5] = '{8'h00, 8'h10, 1, 32'h304, 32'h304, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_order = '0;
    clr_snap();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_last",  64'(out_last),  64'h0);
    chk("rst_drop",      64'(drop_pulse), 64'h0);
    chk("rst_out_addr",  64'(out_addr),  64'h0);
    reset_n = 1'b1;
    tick();

    // Slots 1 and 5, consumer always ready.
    clr_snap();
    set_slot(1, 12'h300, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1888);
    set_slot(5, 12'h341, 32'hFF, 32'h0, 32'h0, 32'h0);
    in_order = 64'd1; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    chk("s1_idle_ready", 64'(in_ready), 64'h1);
    chk("s1_idle_valid", 64'(out_valid), 64'h0);
    tick();
    in_valid = 1'b0;
    chk("s1_b1_valid", 64'(out_valid), 64'h1);
    chk("s1_b1_addr",  64'(out_addr),  64'h300);
    chk("s1_b1_wmask", 64'(out_wmask), 64'hFFFF_FFFF);
    chk("s1_b1_wdata", 64'(out_wdata), 64'h1888);
    chk("s1_b1_last",  64'(out_last),  64'h0);
    chk("s1_b1_order", out_order, 64'd1);
    tick();
    chk("s1_b2_valid", 64'(out_valid), 64'h1);
    chk("s1_b2_addr",  64'(out_addr),  64'h341);
    chk("s1_b2_rmask", 64'(out_rmask), 64'hFF);
    chk("s1_b2_last",  64'(out_last),  64'h1);
    tick();
    chk("s1_done_valid", 64'(out_valid), 64'h0);
    chk("s1_done_ready", 64'(in_ready),  64'h1);

    // Same snapshot, consumer stalls three cycles on beat 1.
    in_order = 64'd2; out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("s2_hold_valid", 64'(out_valid), 64'h1);
      chk("s2_hold_addr",  64'(out_addr),  64'h300);
      chk("s2_hold_wdata", 64'(out_wdata), 64'h1888);
      chk("s2_hold_ready", 64'(in_ready),  64'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("s2_b1_ready", 64'(in_ready), 64'h0);
    tick();
    chk("s2_b2_addr",  64'(out_addr), 64'h341);
    chk("s2_b2_ready", 64'(in_ready), 64'h1);
    tick();
    chk("s2_done_valid", 64'(out_valid), 64'h0);

    // Empty snapshot is dropped.
    clr_snap();
    in_order = 64'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s3_valid", 64'(out_valid), 64'h0);
    chk("s3_drop",  64'(drop_pulse), 64'h1);
    chk("s3_ready", 64'(in_ready), 64'h1);
    tick();
    chk("s3_drop_end", 64'(drop_pulse), 64'h0);
    chk("s3_valid2", 64'(out_valid), 64'h0);

    // Back-to-back single-slot snapshots, no bubble.
    clr_snap();
    set_slot(0, 12'h100, 32'h1, 32'h0, 32'hA, 32'h0);
    in_order = 64'd20; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("s4_a_addr", 64'(out_addr), 64'h100);
    chk("s4_a_last", 64'(out_last), 64'h1);
    clr_snap();
    set_slot(2, 12'h102, 32'h0, 32'h3, 32'h0, 32'hB);
    in_order = 64'd21;
    #1;
    chk("s4_a_in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    chk("s4_b_valid", 64'(out_valid), 64'h1);
    chk("s4_b_addr",  64'(out_addr),  64'h102);
    chk("s4_b_order", out_order, 64'd21);
    chk("s4_b_wdata", 64'(out_wdata), 64'hB);
    tick();
    chk("s4_done_valid", 64'(out_valid), 64'h0);

    // Reset during beat 2 of 4 discards the rest.
    clr_snap();
    for (int s = 0; s < 4; s++) set_slot(s, 12'(12'h200 + s), 32'hF, 32'h0, 32'h0, 32'h0);
    in_order = 64'd50; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("s5_b2_addr", 64'(out_addr), 64'h201);
    reset_n = 1'b0;
    #1;
    chk("s5_rst_valid", 64'(out_valid), 64'h0);
    chk("s5_rst_ready", 64'(in_ready),  64'h0);
    chk("s5_rst_last",  64'(out_last),  64'h0);
    chk("s5_rst_addr",  64'(out_addr),  64'h0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("s5_post_valid", 64'(out_valid), 64'h0);
      chk("s5_post_drop",  64'(drop_pulse), 64'h0);
      tick();
    end
    chk("s5_post_ready", 64'(in_ready), 64'h1);

    // Vector table: slot selections against expected beat count, first/last address, drop.
    for (int i = 0; i < 6; i++) begin
      int n, nlast;
      logic [31:0] first_a, last_a;
      logic got_drop;
      n = 0; nlast = 0; first_a = '0; last_a = '0; got_drop = 1'b0;
      clr_snap();
      for (int s = 0; s < NS; s++)
        set_slot(s, 12'(12'h300 + s), tbl[i].rsel[s] ? 32'hFF : 32'h0,
                 tbl[i].wsel[s] ? 32'hFFFF_0000 : 32'h0, 32'($urandom), 32'($urandom));
      in_order = 64'(100 + i); in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if (drop_pulse) got_drop = 1'b1;
        if (out_valid) begin
          n++;
          if (n == 1) first_a = out_addr;
          if (out_last) begin
            last_a = out_addr;
            nlast++;
          end
        end
        tick();
      end
      chk($sformatf("tbl%0d_n", i),     64'(n),        64'(tbl[i].exp_n));
      chk($sformatf("tbl%0d_first", i), 64'(first_a),  64'(tbl[i].exp_first));
      chk($sformatf("tbl%0d_last", i),  64'(last_a),   64'(tbl[i].exp_last));
      chk($sformatf("tbl%0d_drop", i),  64'(got_drop), 64'(tbl[i].exp_drop));
      chk($sformatf("tbl%0d_nlast", i), 64'(nlast),    64'(tbl[i].exp_n != 0));
    end

`ifdef UVMA_RVFI_CSR_SER_ORDER_CHK_EN
    // Repeated order sets the sticky error until reset.
    do_reset();
    clr_snap();
    in_order = 64'd10; in_valid = 1'b1;
    tick();
    chk("oc_first", 64'(err_order), 64'h0);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("oc_sticky", 64'(err_order), 64'h1);
      tick();
    end
    reset_n = 1'b0;
    tick();
    chk("oc_reset", 64'(err_order), 64'h0);
    reset_n = 1'b1;
`endif

    // Randomized traffic against the beat queue model.
    do_reset();
    q.delete();
    exp_drop = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 40; c++) rand_cycle(1'b0);
    chk("rnd_drain_q", 64'(q.size()), 64'h0);
    chk("rnd_drain_valid", 64'(out_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uvma_rvfi_csr_serializer.md
Name: uvma_rvfi_csr_serializer

Overview:
- Scheduler that shares the single generic RVFI CSR channel (addr/rmask/wmask/rdata/wdata) among NUM_SLOTS named CSR slots.
- Captures one retired instruction's named-CSR snapshot per handshake.
- Emits one beat per accessed slot, in ascending slot order, over a valid/ready output.
- Sits between the RVFI tap and the CSR monitor/scoreboard, so per-CSR checks consume a serial stream.

Parameters:
- XLEN, 32, CSR data/mask width.
- NUM_SLOTS, 8, number of named CSR slots sampled per retirement (1..32).
- ORDER_W, 64, width of the instruction order tag.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  retirement snapshot valid.
- in_ready  out  1  serializer can accept a snapshot.
- in_order  in  ORDER_W  rvfi order of the retiring instruction.
- in_addr  in  NUM_SLOTS*12  CSR address per slot.
- in_rmask  in  NUM_SLOTS*XLEN  read mask per slot.
- in_wmask  in  NUM_SLOTS*XLEN  write mask per slot.
- in_rdata  in  NUM_SLOTS*XLEN  read data per slot.
- in_wdata  in  NUM_SLOTS*XLEN  write data per slot.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts beat.
- out_order  out  ORDER_W  order tag of the current beat.
- out_addr  out  XLEN  CSR address, zero-extended from 12 bits.
- out_rmask / out_wmask / out_rdata / out_wdata  out  XLEN each  slot values.
- out_last  out  1  final beat of this instruction.
- drop_pulse  out  1  one-cycle pulse: an accepted snapshot had no active slot.

Behaviour:
- Slot i is active iff (rmask[i] | wmask[i]) != 0. active_vec is computed at capture.
- Snapshot and active_vec are registered on in_valid && in_ready.
- FSM has two states: IDLE and EMIT.
- IDLE:
  - in_ready = 1.
  - On accept with active_vec != 0: go to EMIT. out_valid rises the next cycle (latency 1) carrying the lowest active slot.
  - On accept with active_vec == 0: stay in IDLE, pulse drop_pulse the next cycle, emit no beat.
- EMIT:
  - Outputs are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, clear the current slot's bit and present the next lowest active slot the following cycle.
  - out_last = 1 when exactly one bit remains set.
- Back-to-back:
  - In EMIT, in_ready = out_ready && out_last.
  - A snapshot accepted on the last-beat handshake is captured that same edge.
  - If it has active slots, the state stays EMIT with no bubble. Otherwise it goes to IDLE with drop_pulse.
- Masks are passed unmodified. Data is not gated by masks; masking is the consumer's job.
- Slot selection uses a lowest-set-bit priority encoder over the remaining vector, clog2(NUM_SLOTS) wide.
- Reset (synchronous, whenever reset_n == 0, including mid-EMIT):
  - State goes to IDLE; the remaining vector is cleared and any in-flight snapshot is discarded without a beat.
  - in_ready = 0, out_valid = 0, out_last = 0, drop_pulse = 0.
  - All out_* data = 0.
- in_valid while in_ready = 0 is legal; the source must hold its values until accepted.

Optional Feature:
- Macro: UVMA_RVFI_CSR_SER_ORDER_CHK_EN.
- Enabled:
  - Adds output err_order (1 bit, sticky, reset 0).
  - It sets when an accepted in_order <= the previously accepted in_order (the first accept after reset is exempt).
  - It clears only on reset.
- Disabled: the port and comparator are absent. Behaviour is otherwise identical.

Decomposition:
- Add to uvma_rvfi_pkg:
  - Typedef uvma_rvfi_csr_ser_state_t {IDLE, EMIT}.
  - Constant CSR_ADDR_W = 12.
  - Typedef for a beat struct (order, addr, rmask, wmask, rdata, wdata, last).
- One natural sub-module: uvma_rvfi_csr_ser_prio_enc, a lowest-set-bit encoder with index and onehot outputs and an any flag.

Test Plan:
- Slots 1 and 5 active (slot1 wmask=0xFFFFFFFF, wdata=0x1888, addr 0x300; slot5 rmask=0xFF, addr 0x341), out_ready=1 → two beats on consecutive cycles: addr 0x300 (last=0), then 0x341 (last=1); first beat one cycle after accept.
- Same snapshot with out_ready low for 3 cycles on beat 1 → beat 1 held constant for 3 cycles; in_ready=0 throughout.
- All masks zero, order=7 → no out_valid; drop_pulse high one cycle after accept; in_ready stays 1.
- Two snapshots back-to-back (slot0 only, then slot2 only), in_valid held → beats on consecutive cycles with no bubble; the second is accepted on the first's out_last handshake.
- reset_n low for one cycle during beat 2 of 4 → out_valid=0 and in_ready=0 that cycle; then IDLE; no remaining beats appear.
- ORDER_CHK_EN defined: accept orders 10 then 10 → err_order=1 from the following cycle and stays set until reset.
